ms_alarm_sched: RTL and testbench

//  Millisecond timekeeper plus NUM_CHAN one-shot alarm channels serving CPU TIME/TIMERST and alarm ops.
//  CPU issues commands over a valid/ready port: read time, reset time, arm channel, cancel channel.
//  One shared 16-bit decrementer is time-multiplexed across channels by a sweep FSM on each ms tick.

---
 rtl/ms_alarm_sched_pkg.sv | 18 +
 rtl/ms_tick_gen.sv | 32 +++
 rtl/ms_alarm_sched.sv | 143 ++++++++++++++
 tb/tb_ms_alarm_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_alarm_sched_pkg.sv
// Shared definitions for the millisecond timekeeper and alarm scheduler.
package ms_alarm_sched_pkg;

  localparam int unsigned WORD_BITS = 16;

  typedef enum logic [1:0] {
    TmrOpRead   = 2'b00,
    TmrOpReset  = 2'b01,
    TmrOpArm    = 2'b10,
    TmrOpCancel = 2'b11
  } tmr_op_e;

  typedef enum logic {
    StIdle,
    StSweep
  } sweep_state_e;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 1..CLKS_PER_MS and pulses tick on the last count.
module ms_tick_gen #(
  parameter int unsigned CLKS_PER_MS = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntBits = $clog2(CLKS_PER_MS + 1);

  logic [CntBits-1:0] count_q, count_d;

  assign tick = (count_q == CntBits'(CLKS_PER_MS));

  always_comb begin
    count_d = count_q + CntBits'(1);
    if (restart || tick) begin
      count_d = CntBits'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= CntBits'(1);
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ms_alarm_sched.sv
// Millisecond time base plus one-shot alarm channels sharing a single decrementer
// that a sweep FSM walks across all channels once per tick.
module ms_alarm_sched
  import ms_alarm_sched_pkg::*;
#(
  parameter int unsigned CLKS_PER_MS = 100000,
  parameter int unsigned NUM_CHAN    = 4,
  parameter int unsigned CHAN_BITS   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CHAN_BITS-1:0] cmd_chan,
  input  logic [WORD_BITS-1:0] cmd_data,
  output logic                 resp_valid,
  output logic [WORD_BITS-1:0] resp_data,
  output logic [WORD_BITS-1:0] ms_time,
  output logic [NUM_CHAN-1:0]  alarm_pending,
  input  logic [NUM_CHAN-1:0]  alarm_clear,
  output logic                 busy
);

  tmr_op_e              op;
  logic                 tick;
  logic                 accept;
  logic                 restart;

  sweep_state_e         state_q, state_d;
  logic [CHAN_BITS-1:0] idx_q, idx_d;
  logic [WORD_BITS-1:0] ms_time_q, ms_time_d;
  logic [WORD_BITS-1:0] remaining_q [NUM_CHAN];
  logic [WORD_BITS-1:0] remaining_d [NUM_CHAN];
  logic [NUM_CHAN-1:0]  active_q, active_d;
  logic [NUM_CHAN-1:0]  pending_q, pending_d;
  logic                 resp_valid_q;
  logic [WORD_BITS-1:0] resp_data_q;

  assign op        = tmr_op_e'(cmd_op);
  // Commands are only taken in IDLE outside a tick, so they never collide with a sweep slot.
  assign cmd_ready = !reset && (state_q == StIdle) && !tick;
  assign accept    = cmd_valid && cmd_ready;
  assign restart   = accept && (op == TmrOpReset);

  ms_tick_gen #(
    .CLKS_PER_MS(CLKS_PER_MS)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    remaining_d = remaining_q;
    active_d    = active_q;
    // Clear first so a same-cycle expiry or ARM d==0 overrides it.
    pending_d   = pending_q & ~alarm_clear;
    ms_time_d   = ms_time_q;

    if (restart) begin
      ms_time_d = '0;
    end else if (tick) begin
      ms_time_d = ms_time_q + WORD_BITS'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StSweep;
          idx_d   = '0;
        end
      end
      StSweep: begin
        if (active_q[idx_q]) begin
          remaining_d[idx_q] = remaining_q[idx_q] - WORD_BITS'(1);
          if (remaining_q[idx_q] == WORD_BITS'(1)) begin
            active_d[idx_q]  = 1'b0;
            pending_d[idx_q] = 1'b1;
          end
        end
        if (idx_q == CHAN_BITS'(NUM_CHAN - 1)) begin
          state_d = StIdle;
        end else begin
          idx_d = idx_q + CHAN_BITS'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      unique case (op)
        TmrOpArm: begin
          if (cmd_data == '0) begin
            active_d[cmd_chan]  = 1'b0;
            pending_d[cmd_chan] = 1'b1;
          end else begin
            remaining_d[cmd_chan] = cmd_data;
            active_d[cmd_chan]    = 1'b1;
            pending_d[cmd_chan]   = 1'b0;
          end
        end
        TmrOpCancel: begin
          active_d[cmd_chan]  = 1'b0;
          pending_d[cmd_chan] = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      ms_time_q    <= '0;
      remaining_q  <= '{default: '0};
      active_q     <= '0;
      pending_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ms_time_q    <= ms_time_d;
      remaining_q  <= remaining_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      resp_valid_q <= accept;
      resp_data_q  <= (accept && (op == TmrOpRead)) ? ms_time_q : '0;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign ms_time       = ms_time_q;
  assign alarm_pending = pending_q;
  assign busy          = (state_q == StSweep);

endmodule

// File: tb/tb_ms_alarm_sched.sv
// Scoreboard bench for ms_alarm_sched: a tick/deadline reference model predicts
// time, pending flags, handshake and responses; a monitor compares every cycle.
module tb_ms_alarm_sched;
  import ms_alarm_sched_pkg::*;

  localparam int unsigned CLKS = 10;
  localparam int unsigned NCH  = 4;
  localparam int unsigned CB   = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [1:0]           cmd_op = 2'b00;
  logic [CB-1:0]        cmd_chan = '0;
  logic [WORD_BITS-1:0] cmd_data = '0;
  logic                 resp_valid;
  logic [WORD_BITS-1:0] resp_data;
  logic [WORD_BITS-1:0] ms_time;
  logic [NCH-1:0]       alarm_pending;
  logic [NCH-1:0]       alarm_clear = '0;
  logic                 busy;

  always #5 clk = ~clk;

  ms_alarm_sched #(
    .CLKS_PER_MS(CLKS),
    .NUM_CHAN   (NCH),
    .CHAN_BITS  (CB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_chan     (cmd_chan),
    .cmd_data     (cmd_data),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .ms_time      (ms_time),
    .alarm_pending(alarm_pending),
    .alarm_clear  (alarm_clear),
    .busy         (busy)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: ms count, ticks-to-go per channel, scheduled expiry cycles.
  bit              m_on = 1'b0;
  longint          m_cyc = 0;
  int              m_pre = 1;
  logic [15:0]     m_time = '0;
  int              m_sweep_left = 0;
  bit              m_active [NCH];
  int              m_left [NCH];
  longint          m_sched [NCH];
  logic [NCH-1:0]  exp_pend = '0;
  logic [15:0]     resp_q [$];
  bit              m_acc, m_tick;

  always @(posedge clk) begin
    m_cyc++;
    if (reset) begin
      m_on = 1'b1;
      m_pre = 1;
      m_time = '0;
      m_sweep_left = 0;
      exp_pend = '0;
      resp_q.delete();
      for (int c = 0; c < NCH; c++) begin
        m_active[c] = 1'b0;
        m_left[c] = 0;
        m_sched[c] = -1;
      end
    end else if (m_on) begin
      m_acc  = cmd_valid && (m_sweep_left == 0) && (m_pre != CLKS);
      m_tick = (m_pre == CLKS);
      if (m_sweep_left > 0) m_sweep_left--;
      exp_pend = exp_pend & ~alarm_clear;
      for (int c = 0; c < NCH; c++) begin
        if (m_sched[c] == m_cyc) begin
          exp_pend[c] = 1'b1;
          m_sched[c] = -1;
        end
      end
      if (m_acc) begin
        resp_q.push_back((cmd_op == TmrOpRead) ? m_time : 16'h0);
        if (cmd_op == TmrOpArm) begin
          if (cmd_data == 0) begin
            m_active[cmd_chan] = 1'b0;
            exp_pend[cmd_chan] = 1'b1;
          end else begin
            m_active[cmd_chan] = 1'b1;
            m_left[cmd_chan] = int'(cmd_data);
            exp_pend[cmd_chan] = 1'b0;
          end
        end else if (cmd_op == TmrOpCancel) begin
          m_active[cmd_chan] = 1'b0;
          exp_pend[cmd_chan] = 1'b0;
        end
      end
      if (m_tick) begin
        m_time++;
        m_pre = 1;
        m_sweep_left = NCH;
        // Channel c is serviced in the c-th sweep cycle; its flag lands at the edge after.
        for (int c = 0; c < NCH; c++) begin
          if (m_active[c]) begin
            m_left[c]--;
            if (m_left[c] == 0) begin
              m_active[c] = 1'b0;
              m_sched[c] = m_cyc + 1 + c;
            end
          end
        end
      end else begin
        m_pre++;
      end
      if (m_acc && cmd_op == TmrOpReset) begin
        m_time = '0;
        m_pre = 1;
      end
    end
  end

  // Monitor: compare state every cycle and pop the scoreboard on each response.
  logic [15:0] exp_resp;
  always @(negedge clk) begin
    if (m_on) begin
      check("ms_time", 32'(ms_time), 32'(m_time));
      check("alarm_pending", 32'(alarm_pending), 32'(exp_pend));
      check("busy", 32'(busy), 32'(m_sweep_left > 0));
      check("cmd_ready", 32'(cmd_ready), 32'(!reset && m_sweep_left == 0 && m_pre != CLKS));
      if (resp_valid || resp_q.size() > 0) begin
        if (resp_q.size() == 0) begin
          check("resp_unexpected", 32'(resp_valid), 32'(0));
        end else begin
          exp_resp = resp_q.pop_front();
          check("resp_valid", 32'(resp_valid), 32'(1));
          if (resp_valid) check("resp_data", 32'(resp_data), 32'(exp_resp));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      alarm_clear = '0;
    end
  endtask

  task automatic rand_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      alarm_clear = ($urandom_range(0, 5) == 0) ? NCH'($urandom) : '0;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [CB-1:0] ch, input logic [15:0] d,
                      output int stalls);
    bit done;
    @(posedge clk); #1;
    alarm_clear = '0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_chan = ch;
    cmd_data = d;
    stalls = 0;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) done = 1'b1;
      else stalls++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!done) check("send_timeout", 32'(0), 32'(1));
  endtask

  int st;
  bit seen;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    idle(35);
    send(TmrOpRead, 0, 0, st);

    send(TmrOpReset, 0, 0, st);
    send(TmrOpArm, 2, 3, st);
    idle(40);

    send(TmrOpArm, 1, 0, st);
    idle(2);
    @(posedge clk); #1 alarm_clear = 4'b0010;
    idle(3);

    // Command offered exactly on a tick cycle stalls through the tick plus the sweep.
    send(TmrOpReset, 0, 0, st);
    idle(8);
    send(TmrOpRead, 0, 0, st);
    check("hold_stall", 32'(st), 32'(NCH + 1));

    send(TmrOpReset, 0, 0, st);
    send(TmrOpArm, 0, 2, st);
    idle(15);
    send(TmrOpCancel, 0, 0, st);
    idle(30);
    send(TmrOpCancel, 3, 0, st);

    send(TmrOpArm, 3, 0, st);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check("sweep_seen", 32'(seen), 32'(1));
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_pending", 32'(alarm_pending), 32'(0));
    check("rst_ms_time", 32'(ms_time), 32'(0));

    send(TmrOpReset, 0, 0, st);
    idle(25);

    for (int n = 0; n < 250; n++) begin
      send(2'($urandom_range(0, 3)), CB'($urandom), 16'($urandom_range(0, 3)), st);
      rand_idle($urandom_range(0, 12));
      if ($urandom_range(0, 60) == 0) begin
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
      end
    end

    idle(60);
    check("resp_queue_drained", 32'(resp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
